// File: rtl/sim_frame_pkg.sv
// sim_frame_pkg: shared types and default constants for the simulation
// frame controller.
//   state_e           - controller state (IDLE, ARMED, DUMP, DONE)
//   DEF_DUMP_START    - default frame number that opens the dump window
//   DEF_DUMP_LEN      - default dump window length in frames (0 = unbounded)
//   DEF_FINISH_FRAME  - default frame number that raises finish (0 = never)
package sim_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_DUMP_START   = 0;
  localparam int unsigned DEF_DUMP_LEN     = 0;
  localparam int unsigned DEF_FINISH_FRAME = 0;

endpackage

// File: rtl/sim_vs_edge.sv
// sim_vs_edge: samples vertical sync on clk and flags its falling edge.
//   clk  - system clock
//   rst  - synchronous active-high reset (sampled vs forced high)
//   vs   - vertical sync input
//   fall - combinational: previous sample high and current vs low
module sim_vs_edge (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic fall
);

  logic vs_l_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_l_q <= 1'b1;
    end else begin
      vs_l_q <= vs;
    end
  end

  assign fall = vs_l_q & ~vs;

endmodule

// File: rtl/sim_frame_ctl.sv
// sim_frame_ctl: counts video frames (vs falling edges) once a ROM download
// has finished and derives a dump window and a finish pulse from the count.
//   clk         - system clock
//   rst         - synchronous active-high reset
//   vs          - vertical sync, sampled on clk
//   downloading - ROM download in progress; holds the counter at 0 and
//                 returns the controller to IDLE
//   frame_cnt   - completed-frame count (wraps modulo 2^32)
//   frame_edge  - one-cycle pulse per counted vs falling edge
//   dump_en     - high while the dump window is open
//   dump_pulse  - one-cycle pulse when dump_en rises
//   finish      - one-cycle pulse when frame_cnt reaches FINISH_FRAME
module sim_frame_ctl
  import sim_frame_pkg::*;
#(
  parameter int unsigned DUMP_START   = DEF_DUMP_START,
  parameter int unsigned DUMP_LEN     = DEF_DUMP_LEN,
  parameter int unsigned FINISH_FRAME = DEF_FINISH_FRAME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        downloading,
  output logic [31:0] frame_cnt,
  output logic        frame_edge,
  output logic        dump_en,
  output logic        dump_pulse,
  output logic        finish
);

  // Frame number that closes the window; wraps modulo 2^32 like the counter.
  localparam logic [31:0] DUMP_END = 32'(DUMP_START + DUMP_LEN);

  logic        fall;
  logic        counted;
  logic [31:0] cnt_inc;

  state_e      state_q,      state_d;
  logic [31:0] frame_cnt_q,  frame_cnt_d;
  logic        frame_edge_q, frame_edge_d;
  logic        dump_en_q,    dump_en_d;
  logic        dump_pulse_q, dump_pulse_d;
  logic        finish_q,     finish_d;
  logic        fin_armed_q,  fin_armed_d;

  sim_vs_edge u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .vs   (vs),
    .fall (fall)
  );

  assign counted = fall && !downloading && (state_q != ST_IDLE);
  assign cnt_inc = frame_cnt_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    frame_edge_d = 1'b0;
    dump_pulse_d = 1'b0;
    finish_d     = 1'b0;
    fin_armed_d  = fin_armed_q;

    if (downloading) begin
      // A download restarts the session: counter held at 0, finish rearmed.
      state_d     = ST_IDLE;
      frame_cnt_d = '0;
      fin_armed_d = 1'b1;
    end else begin
      if (counted) begin
        frame_cnt_d  = cnt_inc;
        frame_edge_d = 1'b1;
        if ((FINISH_FRAME != 32'd0) && fin_armed_q && (cnt_inc == FINISH_FRAME)) begin
          finish_d    = 1'b1;
          fin_armed_d = 1'b0;
        end
      end

      // Transitions compare against the incremented count so that dump_en
      // changes in the same cycle frame_cnt shows the boundary value.
      case (state_q)
        ST_IDLE: begin
          if (DUMP_START == 32'd0) begin
            state_d      = ST_DUMP;
            dump_pulse_d = 1'b1;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (counted && (cnt_inc == DUMP_START)) begin
            state_d      = ST_DUMP;
            dump_pulse_d = 1'b1;
          end
        end
        ST_DUMP: begin
          if ((DUMP_LEN != 32'd0) && counted && (cnt_inc == DUMP_END)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
      endcase
    end

    dump_en_d = (state_d == ST_DUMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      frame_edge_q <= 1'b0;
      dump_en_q    <= 1'b0;
      dump_pulse_q <= 1'b0;
      finish_q     <= 1'b0;
      fin_armed_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_edge_q <= frame_edge_d;
      dump_en_q    <= dump_en_d;
      dump_pulse_q <= dump_pulse_d;
      finish_q     <= finish_d;
      fin_armed_q  <= fin_armed_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign frame_edge = frame_edge_q;
  assign dump_en    = dump_en_q;
  assign dump_pulse = dump_pulse_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_sim_frame_ctl.sv
// Testbench for sim_frame_ctl: four instances with different window/finish
// parameters share one stimulus stream. A frame-level reference model pushes
// expected pulse events into a scoreboard queue; a monitor on the falling
// clock edge pops and compares them and also checks count and dump_en levels.
module tb_sim_frame_ctl;

  localparam int unsigned NDUT = 4;
  localparam int unsigned P_DS [NDUT] = '{0, 5, 2, 3};
  localparam int unsigned P_DL [NDUT] = '{0, 2, 0, 3};
  localparam int unsigned P_FF [NDUT] = '{0, 7, 2, 0};

  logic clk = 1'b0;
  logic rst;
  logic vs;
  logic downloading;

  logic [31:0] cnt_w [NDUT];
  logic        fe_w  [NDUT];
  logic        en_w  [NDUT];
  logic        dp_w  [NDUT];
  logic        fin_w [NDUT];

  always #5 clk = ~clk;

  sim_frame_ctl #(.DUMP_START(P_DS[0]), .DUMP_LEN(P_DL[0]), .FINISH_FRAME(P_FF[0])) u_a (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(cnt_w[0]), .frame_edge(fe_w[0]), .dump_en(en_w[0]),
    .dump_pulse(dp_w[0]), .finish(fin_w[0]));

  sim_frame_ctl #(.DUMP_START(P_DS[1]), .DUMP_LEN(P_DL[1]), .FINISH_FRAME(P_FF[1])) u_b (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(cnt_w[1]), .frame_edge(fe_w[1]), .dump_en(en_w[1]),
    .dump_pulse(dp_w[1]), .finish(fin_w[1]));

  sim_frame_ctl #(.DUMP_START(P_DS[2]), .DUMP_LEN(P_DL[2]), .FINISH_FRAME(P_FF[2])) u_c (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(cnt_w[2]), .frame_edge(fe_w[2]), .dump_en(en_w[2]),
    .dump_pulse(dp_w[2]), .finish(fin_w[2]));

  sim_frame_ctl #(.DUMP_START(P_DS[3]), .DUMP_LEN(P_DL[3]), .FINISH_FRAME(P_FF[3])) u_d (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .frame_cnt(cnt_w[3]), .frame_edge(fe_w[3]), .dump_en(en_w[3]),
    .dump_pulse(dp_w[3]), .finish(fin_w[3]));

  typedef struct {
    int unsigned id;
    int unsigned cyc;
    logic [31:0] cnt;
    logic        fe;
    logic        dp;
    logic        fin;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_fail;
  bit          run;
  bit          done_req;
  bit          drained;
  int unsigned wrap_seq;

  // Reference model state, per instance, in frame/session terms.
  logic [31:0] m_cnt    [NDUT];
  bit          m_live   [NDUT];  // session running (download over, start cycle passed)
  bit          m_open   [NDUT];  // window start frame reached this session
  bit          m_closed [NDUT];  // window end frame reached this session
  bit          m_farm   [NDUT];  // finish still allowed this session
  bit          m_vsp    [NDUT];  // previous vs sample
  bit          m_en     [NDUT];

  initial begin : model
    int unsigned wrap_seen;
    bit fall, fe, dp, fn;
    wrap_seen = 0;
    cyc = 0;
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i] = '0; m_live[i] = 0; m_open[i] = 0; m_closed[i] = 0;
      m_farm[i] = 1; m_vsp[i] = 1; m_en[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (wrap_seq != wrap_seen) begin
        wrap_seen = wrap_seq;
        m_cnt[0]  = 32'hFFFF_FFFF;
      end
      for (int i = 0; i < NDUT; i++) begin
        fe = 0; dp = 0; fn = 0;
        if (rst) begin
          m_cnt[i] = '0; m_live[i] = 0; m_open[i] = 0; m_closed[i] = 0;
          m_farm[i] = 1; m_vsp[i] = 1;
        end else begin
          fall = m_vsp[i] && !vs;
          m_vsp[i] = vs;
          if (downloading) begin
            m_cnt[i] = '0; m_live[i] = 0; m_open[i] = 0; m_closed[i] = 0;
            m_farm[i] = 1;
          end else if (!m_live[i]) begin
            m_live[i] = 1;
            if (P_DS[i] == 0) begin
              m_open[i] = 1;
              dp = 1;
            end
          end else if (fall) begin
            m_cnt[i] = m_cnt[i] + 32'd1;
            fe = 1;
            if (P_FF[i] != 0 && m_farm[i] && m_cnt[i] == P_FF[i]) begin
              fn = 1;
              m_farm[i] = 0;
            end
            if (!m_open[i] && m_cnt[i] == P_DS[i]) begin
              m_open[i] = 1;
              dp = 1;
            end else if (m_open[i] && !m_closed[i] && P_DL[i] != 0 &&
                         m_cnt[i] == 32'(P_DS[i] + P_DL[i])) begin
              m_closed[i] = 1;
            end
          end
        end
        m_en[i] = m_open[i] && !m_closed[i];
        if (fe || dp || fn)
          sb_q.push_back('{id: i, cyc: cyc, cnt: m_cnt[i], fe: fe, dp: dp, fin: fn});
      end
    end
  end

  task automatic chk(input string nm, input int unsigned i,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, i, cyc, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   hit [NDUT];
    n_chk = 0;
    n_fail = 0;
    drained = 0;
    forever begin
      @(negedge clk);
      if (run) begin
        for (int i = 0; i < NDUT; i++) hit[i] = 0;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          e = sb_q.pop_front();
          hit[e.id] = 1;
          chk("frame_edge", e.id, 32'(fe_w[e.id]), 32'(e.fe));
          chk("dump_pulse", e.id, 32'(dp_w[e.id]), 32'(e.dp));
          chk("finish",     e.id, 32'(fin_w[e.id]), 32'(e.fin));
          chk("event_cnt",  e.id, cnt_w[e.id], e.cnt);
        end
        for (int i = 0; i < NDUT; i++) begin
          if (!hit[i])
            chk("spurious_pulse", i, {29'd0, fe_w[i], dp_w[i], fin_w[i]}, 32'd0);
          chk("frame_cnt", i, cnt_w[i], m_cnt[i]);
          chk("dump_en", i, 32'(en_w[i]), 32'(m_en[i]));
        end
        if (done_req && !drained) begin
          chk("queue_empty", 0, sb_q.size(), 32'd0);
          drained = 1;
        end
      end
    end
  end

  task automatic frame();
    vs = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    vs = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    int unsigned r;
    run = 0;
    done_req = 0;
    wrap_seq = 0;
    rst = 1'b1;
    vs = 1'b1;
    downloading = 1'b0;
    idle(3);
    run = 1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // First session straight out of reset: windows open/close, finish fires.
    repeat (9) frame();

    // Falls during a download are ignored; counting resumes from 1.
    downloading = 1'b1;
    repeat (4) frame();
    downloading = 1'b0;
    idle(2);
    repeat (4) frame();
    // Interrupt an open window with a download, then let it reopen.
    downloading = 1'b1;
    idle(2);
    downloading = 1'b0;
    idle(1);
    repeat (5) frame();

    // Counter wrap on the first instance: preload all-ones, then one fall.
    @(negedge clk);
    vs = 1'b0;
    #2;
    force u_a.frame_cnt_q = 32'hFFFF_FFFF;
    wrap_seq++;
    #1;
    release u_a.frame_cnt_q;
    @(negedge clk);
    vs = 1'b1;
    idle(2);
    repeat (2) frame();

    // Reset in the middle of an open window.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    repeat (3) frame();

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        frame();
      end else if (r < 80) begin
        downloading = 1'b1;
        repeat ($urandom_range(0, 3)) frame();
        idle($urandom_range(0, 2));
        downloading = 1'b0;
      end else if (r < 86) begin
        downloading = 1'b1;
        idle(1);
        downloading = 1'b0;
      end else if (r < 89) begin
        rst = 1'b1;
        idle($urandom_range(1, 2));
        rst = 1'b0;
      end else begin
        vs = $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0;
        idle($urandom_range(1, 3));
        vs = 1'b1;
        idle(1);
      end
    end

    idle(4);
    done_req = 1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_frame_ctl.md
SIM_FRAME_CTL -- requirements
Module: sim_frame_ctl

Interface
REQ-001 SHALL have parameter DUMP_START, default 0: frame number at which the dump window opens.
REQ-002 SHALL have parameter DUMP_LEN, default 0: dump window length in frames; 0 = unbounded.
REQ-003 SHALL have parameter FINISH_FRAME, default 0: frame number that raises finish; 0 = never.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vs  input  1  vertical sync (VGA_VS), asynchronous to nothing, sampled on clk.
REQ-007 SHALL have port downloading  input  1  ROM download in progress (led).
REQ-008 SHALL have port frame_cnt  output  32  completed-frame count.
REQ-009 SHALL have port frame_edge  output  1  one-cycle pulse per counted vs falling edge.
REQ-010 SHALL have port dump_en  output  1  high while the dump window is open.
REQ-011 SHALL have port dump_pulse  output  1  one-cycle pulse when dump_en rises.
REQ-012 SHALL have port finish  output  1  one-cycle pulse when frame_cnt reaches FINISH_FRAME.

Function
REQ-013 SHALL register vs into vs_l each cycle; fall = vs_l AND NOT vs.
REQ-014 SHALL assert frame_edge and increment frame_cnt in the cycle after fall, only when downloading is low and state is not IDLE.
REQ-015 SHALL wrap frame_cnt from 0xFFFF_FFFF to 0 with no other side effect.
REQ-016 SHALL clear frame_cnt to 0 every cycle downloading is high; vs_l keeps tracking vs.
REQ-017 SHALL implement states IDLE, ARMED, DUMP, DONE.
REQ-018 IDLE: stays while downloading=1; on downloading=0 goes to DUMP if DUMP_START=0 (dump_pulse asserted), else ARMED.
REQ-019 ARMED: on a counted edge whose new frame_cnt equals DUMP_START goes to DUMP; dump_en and dump_pulse rise in the same cycle frame_cnt shows DUMP_START.
REQ-020 DUMP: with DUMP_LEN≠0, on a counted edge whose new frame_cnt equals DUMP_START+DUMP_LEN (32-bit modulo) goes to DONE; with DUMP_LEN=0 stays.
REQ-021 DONE: terminal until reset or downloading rises; dump_en low.
REQ-022 dump_en SHALL be a registered output, high exactly in DUMP.
REQ-023 downloading rising in any state SHALL force IDLE next cycle, dump_en low, no dump_pulse, no finish.
REQ-024 finish SHALL pulse once per download session, on the counted edge whose new frame_cnt equals FINISH_FRAME (FINISH_FRAME≠0), independent of state; rearmed when returning to IDLE.
REQ-025 A fall coincident with downloading high SHALL be ignored (no count, no pulse).
REQ-026 Simultaneous DUMP entry and finish on the same edge SHALL assert both pulses.

Reset
REQ-027 On rst: state=IDLE, frame_cnt=0, vs_l=1, frame_edge=0, dump_en=0, dump_pulse=0, finish=0, finish-armed flag set.
REQ-028 rst mid-DUMP SHALL drop dump_en next cycle without dump_pulse or finish.

Structure
REQ-029 State typedef (2-bit enum) and default parameter constants SHALL live in shared package sim_frame_pkg.
REQ-030 vs sampling and fall detection SHALL be sub-module sim_vs_edge (clk, rst, vs, fall); the rest stays flat.

Verification
REQ-031 Reset, downloading=0, DUMP_START=0, 3 vs falls -> dump_pulse one cycle after IDLE exit, frame_cnt 1,2,3, dump_en held high.
REQ-032 DUMP_START=5, DUMP_LEN=2 -> dump_en rises with frame_cnt=5, falls with frame_cnt=7, state DONE, single dump_pulse.
REQ-033 downloading high for 4 falls, then low, then 2 falls -> frame_cnt 0 during download, then 1,2; no frame_edge during download.
REQ-034 DUMP_START=3, downloading raised at frame_cnt=4 in DUMP -> dump_en low next cycle, frame_cnt=0, IDLE; after release, dump reopens at frame_cnt=3.
REQ-035 FINISH_FRAME=2, DUMP_START=2 -> finish and dump_pulse in same cycle at frame_cnt=2; no second finish at later frames.
REQ-036 frame_cnt forced to 0xFFFF_FFFF, one fall -> frame_cnt=0, frame_edge pulses, state unchanged.
